// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default word width, register operation codes
// and the even-parity helper used by parity-protected storage (REGISTER_PARITY_EN).
package cpu_pkg;

  localparam int WORD_WIDTH       = 16;
  localparam int PARITY_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    REG_HOLD,
    REG_LOAD,
    REG_CLEAR
  } reg_op_e;

  // Callers zero-extend narrower words; extra zero bits never change parity.
  function automatic logic even_parity(input logic [PARITY_MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/data_register_if.sv
// Data bus of a datapath storage register; the parity signals exist only when
// REGISTER_PARITY_EN is defined.
interface data_register_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
);

  logic [WIDTH-1:0] in;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] out;
`ifdef REGISTER_PARITY_EN
  logic             par;
  logic             par_err;
`endif

`ifdef REGISTER_PARITY_EN
  modport master (output in, en, clr, input out, par, par_err);
  modport slave  (input in, en, clr, output out, par, par_err);
`else
  modport master (output in, en, clr, input out);
  modport slave  (input in, en, clr, output out);
`endif

endinterface

// File: rtl/data_register.sv
// WIDTH-bit storage register with load enable and synchronous clear; optional
// stored even parity and upset detection when REGISTER_PARITY_EN is defined.
module data_register
  import cpu_pkg::*;
#(
  parameter int               WIDTH       = WORD_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic            clk,
  input logic            reset,
  data_register_if.slave bus
);

  reg_op_e          op;
  logic [WIDTH-1:0] stored_value;

`ifdef REGISTER_PARITY_EN
  localparam logic RESET_PARITY = even_parity(PARITY_MAX_WIDTH'(RESET_VALUE));
  logic stored_par;
`endif

  // Clear outranks load enable.
  always_comb begin
    op = REG_HOLD;
    if (bus.clr) begin
      op = REG_CLEAR;
    end else if (bus.en) begin
      op = REG_LOAD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stored_value <= RESET_VALUE;
`ifdef REGISTER_PARITY_EN
      stored_par   <= RESET_PARITY;
`endif
    end else begin
      case (op)
        REG_CLEAR: begin
          stored_value <= RESET_VALUE;
`ifdef REGISTER_PARITY_EN
          stored_par   <= RESET_PARITY;
`endif
        end
        REG_LOAD: begin
          stored_value <= bus.in;
`ifdef REGISTER_PARITY_EN
          stored_par   <= even_parity(PARITY_MAX_WIDTH'(bus.in));
`endif
        end
        default: begin
          stored_value <= stored_value;
`ifdef REGISTER_PARITY_EN
          stored_par   <= stored_par;
`endif
        end
      endcase
    end
  end

  assign bus.out = stored_value;

`ifdef REGISTER_PARITY_EN
  // Recomputed from the visible word so any flipped stored bit shows up.
  assign bus.par     = stored_par;
  assign bus.par_err = even_parity(PARITY_MAX_WIDTH'(bus.out)) != stored_par;
`endif

endmodule

// File: tb/tb_data_register.sv
// Scoreboard bench for data_register: stimulus queues expected words, a monitor
// compares them after each rising edge; parity checks run under REGISTER_PARITY_EN.
module tb_data_register;
  import cpu_pkg::*;

  typedef struct {
    string       name;
    logic [15:0] value;
  } expect_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] flipped;
  expect_t     sb_q[$];
  int          checks   = 0;
  int          failures = 0;

  data_register_if #(.WIDTH(16)) bus_if ();

  data_register #(
    .WIDTH       (16),
    .RESET_VALUE (16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs on the falling edge and queues the word the
  // register must show after the following rising edge.
  task automatic applyStimulus(input string name, input logic rst_val,
                               input logic [15:0] data, input logic load,
                               input logic clear, input logic [15:0] expected);
    expect_t e;
    @(negedge clk);
    reset     = rst_val;
    bus_if.in  = data;
    bus_if.en  = load;
    bus_if.clr = clear;
    e.name  = name;
    e.value = expected;
    sb_q.push_back(e);
  endtask

  task automatic drainScoreboard(input string name);
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s: pending %0d expected 0", name, sb_q.size());
    end
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput(e.name, bus_if.out, e.value);
      end
    end
  end

  // The stored word must be gone shortly after reset falls, without a clock edge.
  always @(negedge reset) begin
    #1;
    checkOutput("async_reset", bus_if.out, 16'h0000);
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin : stimulus
    reset      = 1'b0;
    bus_if.in  = 16'hFFFF;
    bus_if.en  = 1'b1;
    bus_if.clr = 1'b0;

    repeat (3) applyStimulus("t1_reset_held", 1'b0, 16'hFFFF, 1'b1, 1'b0, 16'h0000);
    applyStimulus("t1_first_capture", 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF);

    applyStimulus("t2_load_aaaa", 1'b1, 16'hAAAA, 1'b1, 1'b0, 16'hAAAA);
    applyStimulus("t2_load_f0f0", 1'b1, 16'hF0F0, 1'b1, 1'b0, 16'hF0F0);
    applyStimulus("t2_load_5555", 1'b1, 16'h5555, 1'b1, 1'b0, 16'h5555);
    applyStimulus("t2_load_0f0f", 1'b1, 16'h0F0F, 1'b1, 1'b0, 16'h0F0F);

    applyStimulus("t3_load_1234", 1'b1, 16'h1234, 1'b1, 1'b0, 16'h1234);
    repeat (3) applyStimulus("t3_hold", 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h1234);

    applyStimulus("t4_load_beef", 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'hBEEF);
    applyStimulus("t4_clr_over_en", 1'b1, 16'h5555, 1'b1, 1'b1, 16'h0000);
    applyStimulus("t4_reload_c3c3", 1'b1, 16'hC3C3, 1'b1, 1'b0, 16'hC3C3);
    applyStimulus("t4_clr_no_en", 1'b1, 16'h7777, 1'b0, 1'b1, 16'h0000);

    applyStimulus("t5_load_f0f0", 1'b1, 16'hF0F0, 1'b1, 1'b0, 16'hF0F0);
    @(posedge clk);
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    applyStimulus("t5_post_reset_hold", 1'b1, 16'h2222, 1'b0, 1'b0, 16'h0000);
    applyStimulus("t5_reload_1357", 1'b1, 16'h1357, 1'b1, 1'b0, 16'h1357);

    drainScoreboard("drain_main");

`ifdef REGISTER_PARITY_EN
    applyStimulus("t6_load_0001", 1'b1, 16'h0001, 1'b1, 1'b0, 16'h0001);
    drainScoreboard("drain_parity");
    @(negedge clk);
    bus_if.en = 1'b0;
    #1;
    checkOutput("t6_par", {15'b0, bus_if.par}, 16'h0001);
    checkOutput("t6_par_err_clean", {15'b0, bus_if.par_err}, 16'h0000);
    flipped = bus_if.out ^ 16'h0100;
    force bus_if.out = flipped;
    #1;
    checkOutput("t6_par_err_upset", {15'b0, bus_if.par_err}, 16'h0001);
    release bus_if.out;
    #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
